mii_tx_arbiter: RTL and testbench

- Shares one 64-bit/8-ctrl MII transmit lane between NUM_SRC frame sources (generators, loopback, pause injector).
- Sources present pre-encoded MII words: start, preamble/SFD, header, payload, FCS and terminate, with matching ctrl.
- Grants the lane one whole frame at a time, round-robin, and fills every unused cycle with IDLE words.
- Enforces a fixed inter-frame gap and a per-frame length watchdog; its output feeds the PHY side and the receive-path frame checker in loopback.

---
 rtl/mii_tx_arbiter.sv | 203 ++++++++++++++++++++
 tb/tb_mii_tx_arbiter.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mii_tx_arbiter.sv
// Round-robin arbiter that hands one shared MII transmit lane to one source
// for a whole frame at a time. It inserts a fixed idle gap after each frame,
// substitutes error words on underrun, and aborts frames that run too long.
module mii_tx_arbiter #(
  parameter int         NUM_SRC    = 4,
  parameter int         DATA_WIDTH = 64,
  parameter int         CTRL_WIDTH = 8,
  parameter logic [7:0] IDLE_CODE  = 8'h07,
  parameter logic [7:0] ERROR_CODE = 8'hFE,
  parameter int         IPG_WORDS  = 2,
  parameter int         MAX_WORDS  = 192
) (
  input  logic                             clk,
  input  logic                             i_rst,
  input  logic [NUM_SRC-1:0]               i_src_req,
  input  logic [NUM_SRC*DATA_WIDTH-1:0]    i_src_data,
  input  logic [NUM_SRC*CTRL_WIDTH-1:0]    i_src_ctrl,
  input  logic [NUM_SRC-1:0]               i_src_valid,
  input  logic [NUM_SRC-1:0]               i_src_last,
  output logic [NUM_SRC-1:0]               o_src_gnt,
  output logic [NUM_SRC-1:0]               o_src_ready,
  output logic [DATA_WIDTH-1:0]            o_tx_data,
  output logic [CTRL_WIDTH-1:0]            o_tx_ctrl,
  output logic                             o_busy,
  output logic                             o_underrun,
  output logic                             o_oversize
);

  localparam int PTR_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int CNT_W = $clog2(MAX_WORDS + 1);
  localparam int GAP_W = $clog2(IPG_WORDS + 1);
  localparam int BYTES = DATA_WIDTH / 8;

  localparam logic [DATA_WIDTH-1:0] IDLE_WORD  = {BYTES{IDLE_CODE}};
  localparam logic [DATA_WIDTH-1:0] ERROR_WORD = {BYTES{ERROR_CODE}};
  localparam logic [CTRL_WIDTH-1:0] CTRL_ALL   = '1;
  localparam logic [CNT_W-1:0]      MAX_CNT    = CNT_W'(MAX_WORDS);
  localparam logic [CNT_W-1:0]      CNT_ONE    = CNT_W'(1);
  localparam logic [GAP_W-1:0]      GAP_LOAD   = GAP_W'(IPG_WORDS);
  localparam logic [GAP_W-1:0]      GAP_ONE    = GAP_W'(1);
  localparam logic [PTR_W:0]        NSRC_EXT   = (PTR_W + 1)'(NUM_SRC);
  localparam logic [PTR_W-1:0]      LAST_SRC   = PTR_W'(NUM_SRC - 1);
  localparam logic [PTR_W-1:0]      PTR_ONE    = PTR_W'(1);

  typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_IPG} state_t;

  state_t                  state_reg, state_next;
  logic [NUM_SRC-1:0]      gnt_reg, gnt_next;
  logic [PTR_W-1:0]        sel_reg, sel_next;
  logic [PTR_W-1:0]        rr_reg, rr_next;
  logic [CNT_W-1:0]        count_reg, count_next;
  logic [GAP_W-1:0]        gap_reg, gap_next;
  logic [DATA_WIDTH-1:0]   data_reg, data_next;
  logic [CTRL_WIDTH-1:0]   ctrl_reg, ctrl_next;
  logic                    underrun_reg, underrun_next;
  logic                    oversize_reg, oversize_next;
  logic [NUM_SRC-1:0]      ready;

  logic [DATA_WIDTH-1:0]   src_data [NUM_SRC];
  logic [CTRL_WIDTH-1:0]   src_ctrl [NUM_SRC];

  // Split the packed source buses into per-source lanes.
  generate
    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_unpack
      assign src_data[gi] = i_src_data[gi*DATA_WIDTH +: DATA_WIDTH];
      assign src_ctrl[gi] = i_src_ctrl[gi*CTRL_WIDTH +: CTRL_WIDTH];
    end
  endgenerate

  logic [DATA_WIDTH-1:0] sel_data;
  logic [CTRL_WIDTH-1:0] sel_ctrl;
  logic                  sel_valid;
  logic                  sel_last;

  assign sel_data  = src_data[sel_reg];
  assign sel_ctrl  = src_ctrl[sel_reg];
  assign sel_valid = i_src_valid[sel_reg];
  assign sel_last  = i_src_last[sel_reg];

  logic [NUM_SRC-1:0] req_rot;
  logic [PTR_W-1:0]   offset;
  logic [PTR_W:0]     sum;
  logic               found;
  logic [PTR_W-1:0]   winner;
  logic [NUM_SRC-1:0] winner_onehot;
  logic [PTR_W-1:0]   rr_after;

  // Round-robin pick: rotate requests so the pointer sits at bit 0, take the
  // lowest set bit, then rotate the offset back to an absolute source index.
  always_comb begin
    req_rot = NUM_SRC'({i_src_req, i_src_req} >> rr_reg);
    found   = |req_rot;
    offset  = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (req_rot[i]) offset = PTR_W'(i);
    end
    sum    = {1'b0, rr_reg} + {1'b0, offset};
    winner = (sum >= NSRC_EXT) ? PTR_W'(sum - NSRC_EXT) : sum[PTR_W-1:0];
    winner_onehot = '0;
    winner_onehot[winner] = 1'b1;
    rr_after = (winner == LAST_SRC) ? '0 : winner + PTR_ONE;
  end

  logic arbitrate;

  // Next-state, lane word and status pulses for the frame-level FSM.
  always_comb begin
    state_next    = state_reg;
    gnt_next      = gnt_reg;
    sel_next      = sel_reg;
    rr_next       = rr_reg;
    count_next    = count_reg;
    gap_next      = gap_reg;
    data_next     = IDLE_WORD;
    ctrl_next     = CTRL_ALL;
    underrun_next = 1'b0;
    oversize_next = 1'b0;
    ready         = '0;
    arbitrate     = 1'b0;
    case (state_reg)
      ST_IDLE: arbitrate = 1'b1;
      ST_SEND: begin
        if (count_reg == MAX_CNT) begin
          // Watchdog: refuse the word, poison the lane and close the frame.
          data_next     = ERROR_WORD;
          oversize_next = 1'b1;
          gnt_next      = '0;
          count_next    = '0;
          gap_next      = GAP_LOAD;
          state_next    = ST_IPG;
        end else begin
          ready = gnt_reg;
          if (sel_valid) begin
            data_next  = sel_data;
            ctrl_next  = sel_ctrl;
            count_next = count_reg + CNT_ONE;
            if (sel_last) begin
              gnt_next   = '0;
              count_next = '0;
              gap_next   = GAP_LOAD;
              state_next = ST_IPG;
            end
          end else begin
            // Source starved mid-frame: mark the hole, frame keeps going.
            data_next     = ERROR_WORD;
            underrun_next = 1'b1;
          end
        end
      end
      ST_IPG: begin
        gap_next = gap_reg - GAP_ONE;
        if (gap_reg == GAP_ONE) begin
          arbitrate  = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
    if (arbitrate && found) begin
      state_next = ST_SEND;
      gnt_next   = winner_onehot;
      sel_next   = winner;
      rr_next    = rr_after;
      count_next = '0;
    end
  end

  // State and registered lane outputs; reset forces an idle lane at once.
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      state_reg    <= ST_IDLE;
      gnt_reg      <= '0;
      sel_reg      <= '0;
      rr_reg       <= '0;
      count_reg    <= '0;
      gap_reg      <= '0;
      data_reg     <= IDLE_WORD;
      ctrl_reg     <= CTRL_ALL;
      underrun_reg <= 1'b0;
      oversize_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      gnt_reg      <= gnt_next;
      sel_reg      <= sel_next;
      rr_reg       <= rr_next;
      count_reg    <= count_next;
      gap_reg      <= gap_next;
      data_reg     <= data_next;
      ctrl_reg     <= ctrl_next;
      underrun_reg <= underrun_next;
      oversize_reg <= oversize_next;
    end
  end

  assign o_src_gnt   = gnt_reg;
  assign o_src_ready = ready;
  assign o_tx_data   = data_reg;
  assign o_tx_ctrl   = ctrl_reg;
  assign o_busy      = (state_reg != ST_IDLE);
  assign o_underrun  = underrun_reg;
  assign o_oversize  = oversize_reg;

endmodule

// File: tb/tb_mii_tx_arbiter.sv
// Directed bench for mii_tx_arbiter: 4 sources, 2-word gap, 8-word watchdog.
module tb_mii_tx_arbiter;

  localparam logic [63:0] IDLE_W = 64'h0707070707070707;
  localparam logic [63:0] ERR_W  = 64'hFEFEFEFEFEFEFEFE;

  logic         clk;
  logic         i_rst;
  logic [3:0]   i_src_req;
  logic [255:0] i_src_data;
  logic [31:0]  i_src_ctrl;
  logic [3:0]   i_src_valid;
  logic [3:0]   i_src_last;
  logic [3:0]   o_src_gnt;
  logic [3:0]   o_src_ready;
  logic [63:0]  o_tx_data;
  logic [7:0]   o_tx_ctrl;
  logic         o_busy;
  logic         o_underrun;
  logic         o_oversize;

  int checks;
  int errors;

  mii_tx_arbiter #(
    .NUM_SRC(4), .DATA_WIDTH(64), .CTRL_WIDTH(8), .IDLE_CODE(8'h07),
    .ERROR_CODE(8'hFE), .IPG_WORDS(2), .MAX_WORDS(8)
  ) dut (
    .clk(clk), .i_rst(i_rst), .i_src_req(i_src_req), .i_src_data(i_src_data),
    .i_src_ctrl(i_src_ctrl), .i_src_valid(i_src_valid), .i_src_last(i_src_last),
    .o_src_gnt(o_src_gnt), .o_src_ready(o_src_ready), .o_tx_data(o_tx_data),
    .o_tx_ctrl(o_tx_ctrl), .o_busy(o_busy), .o_underrun(o_underrun),
    .o_oversize(o_oversize)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_src();
    i_src_req   = '0;
    i_src_valid = '0;
    i_src_last  = '0;
    i_src_data  = '0;
    i_src_ctrl  = '0;
  endtask

  task automatic drive_word(input int s, input logic [63:0] d, input logic [7:0] c, input logic l);
    i_src_valid    = '0;
    i_src_valid[s] = 1'b1;
    i_src_last     = '0;
    i_src_last[s]  = l;
    i_src_data[s*64 +: 64] = d;
    i_src_ctrl[s*8 +: 8]   = c;
  endtask

  task automatic apply_reset();
    i_rst = 1'b1;
    clear_src();
    repeat (2) @(posedge clk);
    #1;
    i_rst = 1'b0;
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    clear_src();
    #1;
    checks++;
    if (o_tx_data !== IDLE_W || o_tx_ctrl !== 8'hFF || o_src_gnt !== 4'b0 || o_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold: got data %h ctrl %h gnt %b busy %b want %h FF 0000 0", o_tx_data, o_tx_ctrl, o_src_gnt, o_busy, IDLE_W);
    end
    apply_reset();
    for (int n = 0; n < 10; n++) begin
      step();
      checks++;
      if (o_tx_data !== IDLE_W || o_tx_ctrl !== 8'hFF || o_src_gnt !== 4'b0 || o_busy !== 1'b0 ||
          o_underrun !== 1'b0 || o_oversize !== 1'b0) begin
        errors++;
        $display("FAIL reset_idle[%0d]: got data %h ctrl %h gnt %b busy %b ur %b ov %b want idle", n, o_tx_data, o_tx_ctrl, o_src_gnt, o_busy, o_underrun, o_oversize);
      end
    end
    $display("reset: 10 idle cycles checked");
  endtask

  task automatic test_single();
    logic [63:0] w [3];
    logic [7:0]  c [3];
    w[0] = 64'hD5555555555555FB; c[0] = 8'h01;
    w[1] = 64'h0011223344556677; c[1] = 8'h00;
    w[2] = 64'h070707FD8899AABB; c[2] = 8'hF0;
    apply_reset();
    i_src_req = 4'b0010;
    step();
    checks++;
    if (o_src_gnt !== 4'b0010 || o_src_ready !== 4'b0010) begin
      errors++;
      $display("FAIL single_gnt: got gnt %b ready %b want 0010 0010", o_src_gnt, o_src_ready);
    end
    checks++;
    if (o_tx_data !== IDLE_W || o_busy !== 1'b1) begin
      errors++;
      $display("FAIL single_pre: got data %h busy %b want %h 1", o_tx_data, o_busy, IDLE_W);
    end
    i_src_req = '0;
    for (int k = 0; k < 3; k++) begin
      drive_word(1, w[k], c[k], k == 2);
      step();
      checks++;
      if (o_tx_data !== w[k] || o_tx_ctrl !== c[k]) begin
        errors++;
        $display("FAIL single_word%0d: got %h/%h want %h/%h", k, o_tx_data, o_tx_ctrl, w[k], c[k]);
      end
    end
    clear_src();
    checks++;
    if (o_src_gnt !== 4'b0 || o_busy !== 1'b1) begin
      errors++;
      $display("FAIL single_end: got gnt %b busy %b want 0000 1", o_src_gnt, o_busy);
    end
    step();
    checks++;
    if (o_tx_data !== IDLE_W || o_tx_ctrl !== 8'hFF || o_busy !== 1'b1) begin
      errors++;
      $display("FAIL single_gap1: got %h/%h busy %b want idle busy 1", o_tx_data, o_tx_ctrl, o_busy);
    end
    step();
    checks++;
    if (o_tx_data !== IDLE_W || o_tx_ctrl !== 8'hFF || o_busy !== 1'b0) begin
      errors++;
      $display("FAIL single_gap2: got %h/%h busy %b want idle busy 0", o_tx_data, o_tx_ctrl, o_busy);
    end
    $display("single: src1 3-word frame, 2 idle words after");
  endtask

  task automatic test_round_robin();
    int          order [3];
    int          s;
    int          other;
    logic [63:0] wd;
    order[0] = 0; order[1] = 2; order[2] = 0;
    apply_reset();
    i_src_req = 4'b0101;
    step();
    for (int k = 0; k < 3; k++) begin
      s = order[k];
      other = (s == 0) ? 2 : 0;
      checks++;
      if (o_src_gnt !== 4'(1 << s) || o_tx_data !== IDLE_W) begin
        errors++;
        $display("FAIL rr_gnt%0d: got gnt %b data %h want %b idle", k, o_src_gnt, o_tx_data, 4'(1 << s));
      end
      for (int j = 0; j < 2; j++) begin
        wd = {8'(k), 8'(j), 48'h123456789ABC};
        drive_word(s, wd, 8'h00, j == 1);
        // Non-granted requester shows junk that must be ignored.
        i_src_valid[other] = 1'b1;
        i_src_data[other*64 +: 64] = 64'hBADBADBADBADBAD0;
        if (k == 2 && j == 1) i_src_req = '0;
        step();
        checks++;
        if (o_tx_data !== wd || o_tx_ctrl !== 8'h00) begin
          errors++;
          $display("FAIL rr_word%0d_%0d: got %h/%h want %h/00", k, j, o_tx_data, o_tx_ctrl, wd);
        end
      end
      i_src_valid = '0;
      i_src_last  = '0;
      step();
      checks++;
      if (o_tx_data !== IDLE_W || o_src_gnt !== 4'b0) begin
        errors++;
        $display("FAIL rr_gap%0d: got data %h gnt %b want idle 0000", k, o_tx_data, o_src_gnt);
      end
      step();
      $display("rr: frame %0d from src%0d", k, s);
    end
    checks++;
    if (o_busy !== 1'b0 || o_src_gnt !== 4'b0 || o_tx_data !== IDLE_W) begin
      errors++;
      $display("FAIL rr_done: got busy %b gnt %b data %h want 0 0000 idle", o_busy, o_src_gnt, o_tx_data);
    end
  endtask

  task automatic test_underrun();
    apply_reset();
    i_src_req = 4'b1000;
    step();
    checks++;
    if (o_src_gnt !== 4'b1000) begin
      errors++;
      $display("FAIL ur_gnt: got %b want 1000", o_src_gnt);
    end
    i_src_req = '0;
    drive_word(3, 64'h55555555555555FB, 8'h01, 1'b0);
    step();
    checks++;
    if (o_tx_data !== 64'h55555555555555FB || o_underrun !== 1'b0) begin
      errors++;
      $display("FAIL ur_w0: got %h ur %b want 55555555555555fb 0", o_tx_data, o_underrun);
    end
    i_src_valid = '0;
    step();
    checks++;
    if (o_tx_data !== ERR_W || o_tx_ctrl !== 8'hFF || o_underrun !== 1'b1) begin
      errors++;
      $display("FAIL ur_err: got %h/%h ur %b want %h/ff 1", o_tx_data, o_tx_ctrl, o_underrun, ERR_W);
    end
    drive_word(3, 64'hCAFEF00D12345678, 8'h00, 1'b0);
    step();
    checks++;
    if (o_tx_data !== 64'hCAFEF00D12345678 || o_underrun !== 1'b0) begin
      errors++;
      $display("FAIL ur_w1: got %h ur %b want cafef00d12345678 0", o_tx_data, o_underrun);
    end
    drive_word(3, 64'h07070707070707FD, 8'hFF, 1'b1);
    step();
    checks++;
    if (o_tx_data !== 64'h07070707070707FD || o_tx_ctrl !== 8'hFF || o_src_gnt !== 4'b0) begin
      errors++;
      $display("FAIL ur_last: got %h/%h gnt %b want 07070707070707fd/ff 0000", o_tx_data, o_tx_ctrl, o_src_gnt);
    end
    clear_src();
    $display("underrun: src3 frame with one error word");
  endtask

  task automatic test_oversize();
    logic [63:0] wd;
    apply_reset();
    i_src_req = 4'b0001;
    step();
    i_src_req = '0;
    for (int i = 0; i < 10; i++) begin
      wd = {32'h0BADF00D, 32'(i)};
      drive_word(0, wd, 8'h00, 1'b0);
      #1;
      checks++;
      if (o_src_ready !== ((i < 8) ? 4'b0001 : 4'b0000)) begin
        errors++;
        $display("FAIL ov_ready%0d: got %b want %b", i, o_src_ready, (i < 8) ? 4'b0001 : 4'b0000);
      end
      step();
      if (i < 8) begin
        checks++;
        if (o_tx_data !== wd || o_oversize !== 1'b0) begin
          errors++;
          $display("FAIL ov_word%0d: got %h ov %b want %h 0", i, o_tx_data, o_oversize, wd);
        end
      end else if (i == 8) begin
        checks++;
        if (o_tx_data !== ERR_W || o_tx_ctrl !== 8'hFF || o_oversize !== 1'b1 ||
            o_underrun !== 1'b0 || o_src_gnt !== 4'b0) begin
          errors++;
          $display("FAIL ov_abort: got %h/%h ov %b ur %b gnt %b want err/ff 1 0 0000", o_tx_data, o_tx_ctrl, o_oversize, o_underrun, o_src_gnt);
        end
      end else begin
        checks++;
        if (o_tx_data !== IDLE_W || o_oversize !== 1'b0 || o_busy !== 1'b1) begin
          errors++;
          $display("FAIL ov_gap: got %h ov %b busy %b want idle 0 1", o_tx_data, o_oversize, o_busy);
        end
      end
    end
    clear_src();
    step();
    step();
    checks++;
    if (o_tx_data !== IDLE_W || o_busy !== 1'b0) begin
      errors++;
      $display("FAIL ov_done: got %h busy %b want idle 0", o_tx_data, o_busy);
    end
    $display("oversize: 8 words passed then abort");
  endtask

  task automatic test_reset_mid();
    apply_reset();
    i_src_req = 4'b0010;
    step();
    i_src_req = '0;
    drive_word(1, 64'h1111111111111111, 8'h00, 1'b0);
    step();
    drive_word(1, 64'h2222222222222222, 8'h00, 1'b0);
    i_rst = 1'b1;
    #1;
    checks++;
    if (o_src_gnt !== 4'b0 || o_src_ready !== 4'b0 || o_tx_data !== IDLE_W ||
        o_tx_ctrl !== 8'hFF || o_busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid: got gnt %b rdy %b data %h ctrl %h busy %b want 0 0 idle ff 0", o_src_gnt, o_src_ready, o_tx_data, o_tx_ctrl, o_busy);
    end
    clear_src();
    step();
    i_rst = 1'b0;
    step();
    checks++;
    if (o_tx_data !== IDLE_W || o_underrun !== 1'b0 || o_oversize !== 1'b0) begin
      errors++;
      $display("FAIL rst_after: got %h ur %b ov %b want idle 0 0", o_tx_data, o_underrun, o_oversize);
    end
    // rr pointer back at 0 picks src1; a stale pointer of 2 would pick src3.
    i_src_req = 4'b1010;
    step();
    checks++;
    if (o_src_gnt !== 4'b0010) begin
      errors++;
      $display("FAIL rst_rr: got %b want 0010", o_src_gnt);
    end
    clear_src();
    $display("reset_mid: abort and rr restart checked");
  endtask

  initial begin
    checks = 0;
    errors = 0;
    i_rst  = 1'b1;
    clear_src();
    test_reset();
    test_single();
    test_round_robin();
    test_underrun();
    test_oversize();
    test_reset_mid();
    apply_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
